// File: rtl/csa_resolver.sv
// Carry-save to binary resolver: result = s + 2c mod 2^W, one Chunk-bit slice per clock.
// Optional overflow flag and pad storage built only when CSA_RES_OVF_EN is defined.
module csa_resolver #(
  parameter  int unsigned Size     = 3072,
  parameter  int unsigned Size_bi  = 54,
  parameter  int unsigned Size_log = 8,
  parameter  int unsigned Chunk    = 64,
  localparam int unsigned W        = Size + Size_bi + Size_log
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] s,
  input  logic [W-1:0] c,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         ovf
);

  localparam int unsigned NCHUNK = (W + 2 + Chunk - 1) / Chunk;
  localparam int unsigned P      = NCHUNK * Chunk;
  localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned LW     = $clog2(P);
`ifdef CSA_RES_OVF_EN
  localparam int unsigned RW     = P;
`else
  localparam int unsigned RW     = W;
`endif

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_e;

  state_e          state_q;
  logic [IW-1:0]   idx_q;
  logic            cy_q;
  logic [RW-1:0]   a_q, b_q, r_q;
  logic            in_ready_q, out_valid_q;

  logic [LW-1:0]   lsb_c;
  logic [P-1:0]    a_ext_c, b_ext_c, r_ext_c;
  logic [Chunk:0]  sum_c;
  logic [RW-1:0]   r_d;
  logic            last_c;

  // Slice adder: operands viewed at padded width so the last slice is always full.
  always_comb begin
    lsb_c   = LW'(idx_q) * LW'(Chunk);
    a_ext_c = P'(a_q);
    b_ext_c = P'(b_q);
    r_ext_c = P'(r_q);
    sum_c   = {1'b0, a_ext_c[lsb_c +: Chunk]} + {1'b0, b_ext_c[lsb_c +: Chunk]}
            + (Chunk + 1)'(cy_q);
    r_ext_c[lsb_c +: Chunk] = sum_c[Chunk-1:0];
    r_d     = RW'(r_ext_c);
    last_c  = (idx_q == IW'(NCHUNK - 1));
  end

`ifdef CSA_RES_OVF_EN
  logic ovf_q;
  logic ovf_next_c;
  // Pad bits W and W+1 of the true sum, plus any final carry, mean the sum reached 2^W.
  assign ovf_next_c = (|r_ext_c[P-1:W]) | sum_c[Chunk];
  assign ovf        = ovf_q;
`else
  logic unused_pad_c;
  assign unused_pad_c = |r_ext_c[P-1:W];
  assign ovf          = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cy_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      r_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef CSA_RES_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= RW'(s);
            b_q        <= RW'({c, 1'b0});
            idx_q      <= '0;
            cy_q       <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= ADD;
          end
        end
        ADD: begin
          r_q  <= r_d;
          cy_q <= sum_c[Chunk];
          if (last_c) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
`ifdef CSA_RES_OVF_EN
            ovf_q       <= ovf_next_c;
`endif
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef CSA_RES_OVF_EN
            ovf_q       <= 1'b0;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = r_q[W-1:0];

endmodule

// File: tb/tb_csa_resolver.sv
// Self-checking bench for csa_resolver; expected results queued at accept, compared at output.
module tb_csa_resolver;

  localparam int unsigned W       = 3134;
  localparam int unsigned LAT     = 49;
  localparam int unsigned PERIOD  = 51;
  localparam int unsigned TIMEOUT = 200;

  typedef struct packed {
    logic [W-1:0] r;
    logic         o;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] s;
  logic [W-1:0] c;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         ovf;

  exp_t        sb[$];
  int unsigned nvec = 0;
  int unsigned nerr = 0;
  int unsigned cyc  = 0;

  csa_resolver dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .s        (s),
    .c        (c),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [W-1:0] sv, input logic [W-1:0] cv);
    exp_t         e;
    logic [W+1:0] full;
    full = (W + 2)'(sv) + (W + 2)'({cv, 1'b0});
    e.r  = full[W-1:0];
`ifdef CSA_RES_OVF_EN
    e.o  = |full[W+1:W];
`else
    e.o  = 1'b0;
`endif
    return e;
  endfunction

  task automatic accept(input logic [W-1:0] sv, input logic [W-1:0] cv, output int unsigned at);
    s = sv; c = cv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    at = cyc;
    sb.push_back(model(sv, cv));
  endtask

  task automatic wait_valid(output int unsigned n);
    n = 0;
    while (!out_valid && n < TIMEOUT) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; s = '0; c = '0;
    repeat (2) @(posedge clk);
    #1;
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    nvec++; if (result !== '0) begin nerr++; $display("FAIL reset_result got low64 %h exp 0", result[63:0]); end
    nvec++; if (ovf !== 1'b0) begin nerr++; $display("FAIL reset_ovf got %b exp 0", ovf); end
    rst_n = 1'b1;
  endtask

  // Runs one transaction and checks latency, value, flag and the return to idle.
  task automatic test_one(input string tag, input logic [W-1:0] sv, input logic [W-1:0] cv);
    int unsigned at, n;
    exp_t        e;
    accept(sv, cv, at);
    wait_valid(n);
    nvec++; if (n != LAT) begin nerr++; $display("FAIL %s latency got %0d exp %0d", tag, n, LAT); end
    e = sb.pop_front();
    nvec++; if (result !== e.r) begin
      nerr++;
      $display("FAIL %s result got top32 %h low64 %h exp top32 %h low64 %h",
               tag, result[W-1 -: 32], result[63:0], e.r[W-1 -: 32], e.r[63:0]);
    end
    nvec++; if (ovf !== e.o) begin nerr++; $display("FAIL %s ovf got %b exp %b", tag, ovf, e.o); end
    handoff();
    nvec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      nerr++; $display("FAIL %s idle got in_ready=%b out_valid=%b exp 1/0", tag, in_ready, out_valid);
    end
  endtask

  task automatic test_simple();
    test_one("simple", W'(5), W'(3));
    nvec++; if (W'(11) !== model(W'(5), W'(3)).r) begin nerr++; $display("FAIL simple_model got %0d exp 11", model(W'(5), W'(3)).r[31:0]); end
  endtask

  task automatic test_ripple();
    logic [W-1:0] sv;
    sv = '0;
    sv[63:0] = '1;
    test_one("ripple", sv, W'(1));
  endtask

  task automatic test_wrap();
    logic [W-1:0] cv;
    test_one("wrap_ones", '1, W'(1));
    cv = '0;
    cv[W-1] = 1'b1;
    test_one("wrap_top", '0, cv);
  endtask

  task automatic test_backpressure();
    int unsigned at, n;
    exp_t        e;
    accept('1, W'(1), at);
    wait_valid(n);
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      nvec++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        nerr++; $display("FAIL bp_hold%0d got out_valid=%b in_ready=%b exp 1/0", i, out_valid, in_ready);
      end
      nvec++; if (result !== e.r || ovf !== e.o) begin
        nerr++; $display("FAIL bp_stable%0d got low64 %h ovf %b exp low64 %h ovf %b",
                         i, result[63:0], ovf, e.r[63:0], e.o);
      end
      if (i == 2) begin s = W'(99); c = W'(77); in_valid = 1'b1; end
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    handoff();
    nvec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      nerr++; $display("FAIL bp_release got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
    end
    repeat (3) @(posedge clk);
    #1;
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL bp_no_extra got out_valid=%b exp 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    int unsigned at;
    accept(W'(123), W'(456), at);
    repeat (20) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    nvec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      nerr++; $display("FAIL rstmid_hs got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
    end
    nvec++; if (result !== '0 || ovf !== 1'b0) begin
      nerr++; $display("FAIL rstmid_data got low64 %h ovf %b exp 0 0", result[63:0], ovf);
    end
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    test_one("after_reset", W'(7), W'(0));
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] rs, rc;
    int unsigned  acc[4];
    int unsigned  n, t;
    exp_t         e;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rs = '0; rc = '0;
      for (int w = 0; w < 99; w++) begin
        rs = {rs[W-33:0], 32'($urandom)};
        rc = {rc[W-33:0], 32'($urandom)};
      end
      s = rs; c = rc; in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < TIMEOUT) begin @(posedge clk); #1; t++; end
      @(posedge clk); #1;
      in_valid = 1'b0;
      acc[i] = cyc;
      sb.push_back(model(rs, rc));
      wait_valid(n);
      nvec++; if (n != LAT) begin nerr++; $display("FAIL b2b%0d latency got %0d exp %0d", i, n, LAT); end
      e = sb.pop_front();
      nvec++; if (result !== e.r || ovf !== e.o) begin
        nerr++; $display("FAIL b2b%0d result got low64 %h ovf %b exp low64 %h ovf %b",
                         i, result[63:0], ovf, e.r[63:0], e.o);
      end
      if (i > 0) begin
        nvec++; if (acc[i] - acc[i-1] != PERIOD) begin
          nerr++; $display("FAIL b2b%0d spacing got %0d exp %0d", i, acc[i] - acc[i-1], PERIOD);
        end
      end
    end
    @(posedge clk); #1;
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL b2b_done_len got out_valid=%b exp 0", out_valid); end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_simple();
    test_ripple();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
